avalon_pio_bank: RTL and testbench



---
 rtl/avalon_pio_pkg.sv | 12 +
 rtl/pio_edge_capture.sv | 40 ++++
 rtl/avalon_pio_bank.sv | 99 +++++++++
 tb/tb_avalon_pio_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register offsets shared by the Avalon PIO bank and its edge-capture block.
package avalon_pio_pkg;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] PIO_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] PIO_IN       = 3'd1;
  localparam logic [ADDR_W-1:0] PIO_IRQ_MASK = 3'd2;
  localparam logic [ADDR_W-1:0] PIO_EDGE_CAP = 3'd3;
  localparam logic [ADDR_W-1:0] PIO_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] PIO_OUTCLR   = 3'd5;
  localparam logic [ADDR_W-1:0] PIO_PULSE    = 3'd6;
  localparam logic [ADDR_W-1:0] PIO_RSVD     = 3'd7;
endpackage

// File: rtl/pio_edge_capture.sv
// pio_edge_capture: input synchroniser, rising-edge capture (W1C, set wins), mask and registered irq.
module pio_edge_capture #(
  parameter int IN_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_i,
  input  logic            mask_we_i,
  input  logic            clr_we_i,
  input  logic [IN_W-1:0] wdata_i,
  output logic [IN_W-1:0] sync_o,
  output logic [IN_W-1:0] mask_o,
  output logic [IN_W-1:0] cap_o,
  output logic            irq_o
);
  logic [IN_W-1:0] s0_q, s1_q, sd_q, mask_q, cap_q, cap_d;
  logic            irq_q;
  always_comb cap_d = (s1_q & ~sd_q) | (cap_q & ~(clr_we_i ? wdata_i : '0));
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= '0;
      s1_q   <= '0;
      sd_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      s0_q   <= in_i;
      s1_q   <= s0_q;
      sd_q   <= s1_q;
      mask_q <= mask_we_i ? wdata_i : mask_q;
      cap_q  <= cap_d;
      irq_q  <= |(cap_q & mask_q);
    end
  end
  assign sync_o = s1_q;
  assign mask_o = mask_q;
  assign cap_o  = cap_q;
  assign irq_o  = irq_q;
endmodule

// File: rtl/avalon_pio_bank.sv
// avalon_pio_bank: Avalon-MM output register with set/clear/one-shot pulses and synchronised inputs.
// Edge capture, IRQ mask and irq exist only when AVALON_PIO_EDGE_CAPTURE_EN is defined.
module avalon_pio_bank
  import avalon_pio_pkg::*;
#(
  parameter int              OUT_W     = 10,
  parameter int              IN_W      = 4,
  parameter logic [OUT_W-1:0] OUT_RESET = '0,
  parameter int              PULSE_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [IN_W-1:0]   in_port,
  output logic [OUT_W-1:0]  out_port,
  output logic              irq
);
  localparam logic [15:0] PLOAD = 16'(PULSE_LEN - 1);
  logic              wr, rd, unused_ok;
  logic [OUT_W-1:0]  wd, data_q, data_d, pmask_q;
  logic [15:0]       pcnt_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [IN_W-1:0]   in_sync, ie_mask, ie_cap;
  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & read;
  assign wd        = writedata[OUT_W-1:0];
  assign unused_ok = ^writedata;
  always_comb
    data_d = !wr                    ? data_q :
             address == PIO_DATA    ? wd :
             address == PIO_OUTSET  ? data_q | wd :
             address == PIO_OUTCLR  ? data_q & ~wd : data_q;
  always_comb begin
    rdata_d = '0;
    case (address)
      PIO_DATA:     rdata_d = 32'(data_q);
      PIO_IN:       rdata_d = 32'(in_sync);
      PIO_IRQ_MASK: rdata_d = 32'(ie_mask);
      PIO_EDGE_CAP: rdata_d = 32'(ie_cap);
      PIO_PULSE:    rdata_d = 32'(pmask_q);
      default:      rdata_d = '0;
    endcase
  end
  // The pulse counter only runs while a mask is live; the last count clears the mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= OUT_RESET;
      pmask_q <= '0;
      pcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      data_q <= data_d;
      if (wr && address == PIO_PULSE) begin
        pmask_q <= wd;
        pcnt_q  <= PLOAD;
      end else if (|pmask_q) begin
        if (pcnt_q == '0) pmask_q <= '0;
        else pcnt_q <= pcnt_q - 16'd1;
      end
      if (rd) rdata_q <= rdata_d;
    end
  end
  assign out_port = data_q | pmask_q;
  assign readdata = rdata_q;
`ifdef AVALON_PIO_EDGE_CAPTURE_EN
  pio_edge_capture #(.IN_W(IN_W)) u_edge (
    .clk       (clk),
    .reset     (reset),
    .in_i      (in_port),
    .mask_we_i (wr && address == PIO_IRQ_MASK),
    .clr_we_i  (wr && address == PIO_EDGE_CAP),
    .wdata_i   (writedata[IN_W-1:0]),
    .sync_o    (in_sync),
    .mask_o    (ie_mask),
    .cap_o     (ie_cap),
    .irq_o     (irq)
  );
`else
  logic [IN_W-1:0] s0_q, s1_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= in_port;
      s1_q <= s0_q;
    end
  end
  assign in_sync = s1_q;
  assign ie_mask = '0;
  assign ie_cap  = '0;
  assign irq     = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_pio_bank.sv
// tb_avalon_pio_bank: directed checks of the PIO bank; a second instance runs with PULSE_LEN=1.
module tb_avalon_pio_bank;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read = 1'b0, write_n = 1'b1;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0, readdata, readdata1, rv;
  logic [3:0]  in_port = '0;
  logic [9:0]  out_port, out1;
  logic        irq, irq1;
  int          checks = 0, errs = 0, cnt;

  always #5 clk = ~clk;

  avalon_pio_bank #(.OUT_W(10), .IN_W(4), .OUT_RESET(10'h155), .PULSE_LEN(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .out_port(out_port), .irq(irq));

  avalon_pio_bank #(.OUT_W(10), .IN_W(4), .OUT_RESET(10'h155), .PULSE_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
    .write_n(write_n), .writedata(writedata), .readdata(readdata1), .in_port(in_port),
    .out_port(out1), .irq(irq1));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick(1);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset;
    reset = 1'b1; address = 3'd0; writedata = 32'h3FF; chipselect = 1'b1; write_n = 1'b0; read = 1'b1;
    tick(2);
    chipselect = 1'b0; write_n = 1'b1; read = 1'b0; reset = 1'b0;
    checks++; if (out_port !== 10'h155) begin errs++; $display("FAIL reset_out got %h want 155", out_port); end
    checks++; if (readdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b want 0", irq); end
    rd(3'd0, rv);
    checks++; if (rv !== 32'h155) begin errs++; $display("FAIL reset_read_data got %h want 155", rv); end
  endtask

  task automatic test_setclr;
    wr(3'd0, 32'h0F0);
    checks++; if (out_port !== 10'h0F0) begin errs++; $display("FAIL data_wr got %h want 0f0", out_port); end
    wr(3'd4, 32'h003);
    checks++; if (out_port !== 10'h0F3) begin errs++; $display("FAIL outset got %h want 0f3", out_port); end
    wr(3'd5, 32'h030);
    checks++; if (out_port !== 10'h0C3) begin errs++; $display("FAIL outclr got %h want 0c3", out_port); end
    rd(3'd4, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL read_outset got %h want 0", rv); end
    rd(3'd5, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL read_outclr got %h want 0", rv); end
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL read_rsvd got %h want 0", rv); end
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, rv);
    checks++; if (rv !== 32'h3FF) begin errs++; $display("FAIL data_upper got %h want 3ff", rv); end
    wr(3'd0, 32'h0AA);
    address = 3'd0; writedata = 32'h155; chipselect = 1'b1; write_n = 1'b0; read = 1'b1;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; read = 1'b0;
    checks++; if (readdata !== 32'h0AA) begin errs++; $display("FAIL rw_same_read got %h want 0aa", readdata); end
    checks++; if (out_port !== 10'h155) begin errs++; $display("FAIL rw_same_write got %h want 155", out_port); end
  endtask

  task automatic test_pulse;
    wr(3'd0, 32'h0);
    wr(3'd6, 32'h001);
    checks++; if (out1 !== 10'h001) begin errs++; $display("FAIL pulse1_on got %h want 001", out1); end
    tick(1);
    checks++; if (out1 !== 10'h000) begin errs++; $display("FAIL pulse1_off got %h want 000", out1); end
    cnt = 1;
    while (out_port[0] && cnt < 100) begin cnt++; tick(1); end
    checks++; if (cnt !== 16) begin errs++; $display("FAIL pulse_len got %0d want 16", cnt); end
    cnt = 0;
    wr(3'd6, 32'h001);
    while (out_port[0] && cnt < 100) begin
      cnt++;
      if (cnt == 8) wr(3'd6, 32'h001);
      else tick(1);
    end
    checks++; if (cnt !== 24) begin errs++; $display("FAIL pulse_retrig got %0d want 24", cnt); end
    wr(3'd6, 32'h2C0);
    rd(3'd6, rv);
    checks++; if (rv !== 32'h2C0) begin errs++; $display("FAIL pulse_read got %h want 2c0", rv); end
    checks++; if (out_port !== 10'h2C0) begin errs++; $display("FAIL pulse_mask_out got %h want 2c0", out_port); end
    wr(3'd6, 32'h0);
    checks++; if (out_port !== 10'h000) begin errs++; $display("FAIL pulse_abort got %h want 000", out_port); end
    wr(3'd6, 32'h00F);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (out_port !== 10'h155) begin errs++; $display("FAIL pulse_reset got %h want 155", out_port); end
    tick(2);
    checks++; if (out_port !== 10'h155) begin errs++; $display("FAIL pulse_reset_hold got %h want 155", out_port); end
  endtask

  task automatic test_in;
    in_port = 4'hA;
    tick(1);
    rd(3'd1, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL in_lag got %h want 0", rv); end
    rd(3'd1, rv);
    checks++; if (rv !== 32'hA) begin errs++; $display("FAIL in_sync got %h want a", rv); end
    in_port = 4'h5;
    tick(3);
    rd(3'd1, rv);
    checks++; if (rv !== 32'h5) begin errs++; $display("FAIL in_sync2 got %h want 5", rv); end
  endtask

`ifdef AVALON_PIO_EDGE_CAPTURE_EN
  task automatic test_edge;
    in_port = 4'h0;
    tick(4);
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h1);
    rd(3'd2, rv);
    checks++; if (rv !== 32'h1) begin errs++; $display("FAIL mask_read got %h want 1", rv); end
    rd(3'd3, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL cap_clean got %h want 0", rv); end
    in_port = 4'h1;
    tick(3);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_early got %b want 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set got %b want 1", irq); end
    rd(3'd3, rv);
    checks++; if (rv !== 32'h1) begin errs++; $display("FAIL cap_set got %h want 1", rv); end
    wr(3'd3, 32'h1);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_hold got %b want 1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_clear got %b want 0", irq); end
    in_port = 4'h3;
    tick(2);
    wr(3'd3, 32'h2);
    rd(3'd3, rv);
    checks++; if (rv !== 32'h2) begin errs++; $display("FAIL set_wins got %h want 2", rv); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_masked got %b want 0", irq); end
    wr(3'd2, 32'h3);
    tick(1);
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_unmask got %b want 1", irq); end
  endtask
`else
  task automatic test_noedge;
    for (int i = 0; i < 4; i++) begin
      in_port = 4'(i * 5 + 3);
      tick(4);
      checks++; if (irq !== 1'b0) begin errs++; $display("FAIL noedge_irq got %b want 0", irq); end
    end
    wr(3'd2, 32'hF);
    rd(3'd2, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL noedge_mask got %h want 0", rv); end
    rd(3'd3, rv);
    checks++; if (rv !== 32'h0) begin errs++; $display("FAIL noedge_cap got %h want 0", rv); end
  endtask
`endif

  initial begin
    test_reset;
    test_setclr;
    test_pulse;
    test_in;
`ifdef AVALON_PIO_EDGE_CAPTURE_EN
    test_edge;
`else
    test_noedge;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
